// File: rtl/local_inject_arbiter_if.sv
// Bundle of the packet-side signals of local_inject_arbiter.
//   req_valid / req_data / req_ready : NumReq on-node sources (ready is one-hot grant)
//   InjectSlotAvail                  : router back-pressure, 1 = slot free this cycle
//   inject_local / inject_receive_local : registered packet and its one-cycle strobe
// Modport slave is the arbiter side; master is the source/router side.
interface local_inject_arbiter_if #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 256
);
  logic [NumReq-1:0]           req_valid;
  logic [NumReq*DataWidth-1:0] req_data;
  logic [NumReq-1:0]           req_ready;
  logic                        InjectSlotAvail;
  logic [DataWidth-1:0]        inject_local;
  logic                        inject_receive_local;

  modport slave (
    input  req_valid, req_data, InjectSlotAvail,
    output req_ready, inject_local, inject_receive_local
  );

  modport master (
    output req_valid, req_data, InjectSlotAvail,
    input  req_ready, inject_local, inject_receive_local
  );
endinterface

// File: rtl/local_inject_arbiter.sv
// Round-robin arbiter sharing the router's local injection port among NumReq
// packet sources, with a run-control FSM that stops after a programmed count.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : one-cycle pulse arming a run (ignored while running)
//   cfg_total   : packets for the run, 0 selects packet_count; sampled on start
//   bus         : packet interface (slave modport), see local_inject_arbiter_if
//   busy, done  : FSM in RUN / DONE
//   inject_cnt  : packets injected in the current or last run
module local_inject_arbiter #(
  parameter int NumReq       = 4,
  parameter int DataWidth    = 256,
  parameter int packet_count = 256,
  parameter int CountWidth   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CountWidth-1:0] cfg_total,
  local_inject_arbiter_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic [CountWidth-1:0] inject_cnt
);

  localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [PtrW-1:0]       rr_ptr;
  logic [CountWidth-1:0] target;
  logic [CountWidth-1:0] cnt_p1;

  logic                  grant_en;
  logic                  win_found;
  logic [PtrW-1:0]       win_idx;
  int                    scan_idx;
  logic                  grant_p0;
  logic [DataWidth-1:0]  data_p0;

  logic [DataWidth-1:0]  inject_local_p1;
  logic                  vld_p1;

  function automatic logic [DataWidth-1:0] mark_valid(input logic [DataWidth-1:0] pkt);
    logic [DataWidth-1:0] r;
    r = pkt;
    r[DataWidth-1] = 1'b1;
    return r;
  endfunction

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] w);
    if (int'(w) == NumReq - 1) return '0;
    return w + 1'b1;
  endfunction

  // ---- stage p0: combinational arbitration ----
  assign grant_en = (state_q == RUN) && bus.InjectSlotAvail && (cnt_p1 < target);

  // Scan from rr_ptr upward, modulo NumReq; first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int k = 0; k < NumReq; k++) begin
      scan_idx = (int'(rr_ptr) + k) % NumReq;
      if (!win_found && bus.req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = PtrW'(scan_idx);
      end
    end
  end

  assign grant_p0      = grant_en && win_found;
  assign bus.req_ready = grant_p0 ? (NumReq'(1) << win_idx) : '0;
  assign data_p0       = bus.req_data[win_idx*DataWidth +: DataWidth];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (grant_p0 && ((cnt_p1 + CountWidth'(1)) == target)) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // ---- stage p1: registered packet, strobe and run control ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      rr_ptr          <= '0;
      target          <= '0;
      cnt_p1          <= '0;
      vld_p1          <= 1'b0;
      inject_local_p1 <= '0;
    end else begin
      state_q <= state_d;
      vld_p1  <= grant_p0;
      if (grant_p0) begin
        rr_ptr          <= next_ptr(win_idx);
        inject_local_p1 <= mark_valid(data_p0);
      end
      // start only matters outside RUN, where no grant can occur.
      if (start && (state_q != RUN)) begin
        target <= (cfg_total == '0) ? CountWidth'(packet_count) : cfg_total;
        cnt_p1 <= '0;
      end else if (grant_p0) begin
        cnt_p1 <= cnt_p1 + CountWidth'(1);
      end
    end
  end

  assign bus.inject_local         = inject_local_p1;
  assign bus.inject_receive_local = vld_p1;
  assign inject_cnt               = cnt_p1;
  assign busy                     = (state_q == RUN);
  assign done                     = (state_q == DONE);

endmodule

// File: tb/tb_local_inject_arbiter.sv
module tb_local_inject_arbiter;

  localparam int NumReq = 4;
  localparam int DW     = 256;
  localparam int CW     = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] cfg_total;
  logic          busy, done;
  logic [CW-1:0] inject_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] pkt [NumReq];
  logic [DW-1:0] vbit;

  local_inject_arbiter_if #(.NumReq(NumReq), .DataWidth(DW)) bus ();

  local_inject_arbiter #(
    .NumReq(NumReq), .DataWidth(DW), .packet_count(256), .CountWidth(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_total(cfg_total),
    .bus(bus.slave), .busy(busy), .done(done), .inject_cnt(inject_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [CW-1:0] n);
    start = 1'b1;
    cfg_total = n;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [DW-1:0] expect_pkt(input int i);
    return pkt[i] | vbit;
  endfunction

  int strobes;
  logic slot;

  initial begin
    vbit = '0;
    vbit[DW-1] = 1'b1;
    for (int i = 0; i < NumReq; i++) begin
      pkt[i] = '0;
      pkt[i][DW-2] = 1'b1;
      pkt[i][31:0] = 32'hC0DE_0000 + 32'(i * 17 + 5);
      pkt[i][140:129] = 12'(i * 12'h111 + 12'h0A5);
      bus.req_data[i*DW +: DW] = pkt[i];
    end
    pkt[1][DW-1] = 1'b1;
    bus.req_data[1*DW +: DW] = pkt[1];
    rst = 1'b1; start = 1'b0; cfg_total = '0;
    bus.req_valid = '0; bus.InjectSlotAvail = 1'b1;

    // Reset / idle
    tick(); tick();
    chk("rst_busy", DW'(busy), '0);
    chk("rst_done", DW'(done), '0);
    chk("rst_cnt", DW'(inject_cnt), '0);
    chk("rst_strobe", DW'(bus.inject_receive_local), '0);
    chk("rst_data", bus.inject_local, '0);
    rst = 1'b0;
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      chk("idle_ready", DW'(bus.req_ready), '0);
      tick();
      chk("idle_strobe", DW'(bus.inject_receive_local), '0);
    end
    chk("idle_busy", DW'(busy), '0);
    chk("idle_done", DW'(done), '0);

    // Round-robin fairness, 8 packets
    pulse_start(8);
    chk("rr_busy", DW'(busy), 1);
    for (int k = 0; k < 8; k++) begin
      chk("rr_ready", DW'(bus.req_ready), DW'(4'b0001 << (k % 4)));
      tick();
      chk("rr_strobe", DW'(bus.inject_receive_local), 1);
      chk("rr_data", bus.inject_local, expect_pkt(k % 4));
    end
    chk("rr_done", DW'(done), 1);
    chk("rr_cnt", DW'(inject_cnt), 8);
    chk("rr_ready_done", DW'(bus.req_ready), '0);
    tick();
    chk("rr_strobe_after", DW'(bus.inject_receive_local), '0);
    chk("rr_data_hold", bus.inject_local, expect_pkt(3));

    // Sparse request with toggling back-pressure (run of 10)
    pulse_start(10);
    bus.req_valid = 4'b0100;
    strobes = 0;
    for (int k = 0; k < 4; k++) begin
      slot = (k % 2 == 0);
      bus.InjectSlotAvail = slot;
      #1;
      chk("bp_ready", DW'(bus.req_ready), slot ? DW'(4'b0100) : '0);
      tick();
      chk("bp_strobe", DW'(bus.inject_receive_local), DW'(slot));
      if (bus.inject_receive_local) strobes++;
      chk("bp_data", bus.inject_local, expect_pkt(2));
    end
    chk("bp_nstrobes", DW'(strobes), 2);
    chk("bp_cnt", DW'(inject_cnt), 2);
    bus.InjectSlotAvail = 1'b1;

    // Pointer skip: pointer is 3 after the req-2 grant; req 0 moves it to 1
    bus.req_valid = 4'b0001;
    #1;
    chk("ps_ready0", DW'(bus.req_ready), DW'(4'b0001));
    tick();
    bus.req_valid = 4'b1001;
    #1;
    chk("ps_ready3", DW'(bus.req_ready), DW'(4'b1000));
    tick();
    chk("ps_data3", bus.inject_local, expect_pkt(3));
    #1;
    chk("ps_ready0b", DW'(bus.req_ready), DW'(4'b0001));
    start = 1'b1; cfg_total = 16'd2;
    tick();
    start = 1'b0;
    chk("ps_start_ignored_cnt", DW'(inject_cnt), 5);
    chk("ps_start_ignored_busy", DW'(busy), 1);
    chk("ps_data0", bus.inject_local, expect_pkt(0));
    bus.req_valid = 4'b0001;
    for (int c = 0; c < 20 && !done; c++) tick();
    chk("ps_done", DW'(done), 1);
    chk("ps_cnt", DW'(inject_cnt), 10);

    // Default total (cfg_total = 0 -> 256), then a run of 3
    pulse_start(0);
    strobes = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (bus.inject_receive_local) strobes++;
    end
    chk("def_nstrobes", DW'(strobes), 256);
    chk("def_done", DW'(done), 1);
    chk("def_cnt", DW'(inject_cnt), 256);
    chk("def_ready_pending", DW'(bus.req_ready), '0);
    pulse_start(3);
    chk("r3_cnt_clear", DW'(inject_cnt), 0);
    strobes = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.inject_receive_local) strobes++;
    end
    chk("r3_nstrobes", DW'(strobes), 3);
    chk("r3_cnt", DW'(inject_cnt), 3);
    chk("r3_done", DW'(done), 1);

    // Reset in the same cycle as a grant
    pulse_start(5);
    bus.req_valid = 4'b1111;
    #1;
    chk("mr_grant_pending", DW'(bus.req_ready != 0), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mr_strobe", DW'(bus.inject_receive_local), '0);
    chk("mr_data", bus.inject_local, '0);
    chk("mr_busy", DW'(busy), '0);
    chk("mr_done", DW'(done), '0);
    chk("mr_cnt", DW'(inject_cnt), '0);
    chk("mr_ready", DW'(bus.req_ready), '0);
    tick();
    chk("mr_strobe2", DW'(bus.inject_receive_local), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/local_inject_arbiter.md
Name: local_inject_arbiter

Overview:
Shares the router's single local injection port between NumReq on-node packet sources, e.g. force-pipeline outputs. Each cycle it arbitrates round-robin among the valid requesters and registers the winner onto inject_local. It honours the router's InjectSlotAvail back-pressure and sets the valid bit. A run-control FSM counts injected packets and stops after a programmed total, so a simulation step has a defined end.

Parameters:
NumReq, 4, number of requesters (2..8)
DataWidth, 256, packet width; bit DataWidth-1 is the valid bit
packet_count, 256, default packet total used when cfg_total is 0
CountWidth, 16, width of packet counters

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high; all state is cleared on the posedge where rst=1
start  input  1  one-cycle pulse; arms a run
cfg_total  input  CountWidth  packets to inject this run; 0 means use packet_count; sampled on start
req_valid  input  NumReq  requester i has a packet
req_data  input  NumReq*DataWidth  packet i occupies bits [i*DataWidth +: DataWidth]
req_ready  output  NumReq  one-hot grant; packet i is accepted this cycle when req_valid[i] & req_ready[i]
InjectSlotAvail  input  1  router can accept a packet this cycle
inject_local  output  DataWidth  packet to the router
inject_receive_local  output  1  inject_local is valid this cycle (one-cycle strobe per packet)
busy  output  1  FSM in RUN
done  output  1  FSM in DONE
inject_cnt  output  CountWidth  packets injected in the current or last run

Behaviour:
- Reset values: req_ready=0, inject_local=0, inject_receive_local=0, busy=0, done=0, inject_cnt=0, rr_ptr=0, FSM=IDLE. Reset in mid-run abandons any in-flight grant and emits no packet on the following cycle.
- FSM states: IDLE, RUN, DONE.
  - IDLE->RUN on start: latch target = (cfg_total==0 ? packet_count : cfg_total) and clear inject_cnt.
  - RUN->DONE on the cycle a grant makes inject_cnt+1 == target.
  - DONE->RUN on start, with a fresh latch and clear.
  - start while in RUN is ignored.
- Grant condition, combinational: grant only when FSM==RUN, InjectSlotAvail==1 and inject_cnt<target.
  - Winner is the first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, ... modulo NumReq.
  - req_ready is one-hot for the winner and 0 otherwise.
  - req_ready never asserts for a requester whose req_valid is 0.
- Pointer update: on a grant to index w, rr_ptr <= (w+1) mod NumReq. With no grant, rr_ptr holds. This gives every continuously-requesting source a grant at least once every NumReq grants.
- Datapath latency is exactly 1 cycle. On the posedge after a grant:
  - inject_local <= req_data[w] with bit DataWidth-1 forced to 1; all other bits pass unchanged.
  - inject_receive_local <= 1.
  - inject_cnt increments on the same edge.
  - With no grant, inject_receive_local <= 0 and inject_local holds its last value.
- Back-pressure: InjectSlotAvail=0 means no grant and no strobe on the next cycle; requests simply wait, with no loss or duplication. InjectSlotAvail is sampled in the grant cycle only.
- Count limit: once inject_cnt==target, no further grants, even with requests pending. Pending requesters keep req_ready=0.
- start together with a grant in DONE/IDLE is impossible, since grants occur only in RUN. When start and a final grant coincide in RUN, start is ignored and the FSM still enters DONE.
- target=1: a single grant, then DONE on the next edge.
- Wrap-around: counters never overflow because grants stop at target (target ≤ 2^CountWidth-1).
- Simultaneous events: all requesters valid with slot available gives one grant per cycle, rotating 0,1,2,3,0...

Test Plan:
- Reset/idle: rst 1 cycle, then req_valid=4'b1111 without start -> req_ready=0 and inject_receive_local=0 for 20 cycles; busy=0, done=0.
- Round-robin fairness: start with cfg_total=8, all valid, InjectSlotAvail=1 -> grants 0,1,2,3,0,1,2,3 on consecutive cycles; each packet appears 1 cycle later with bit255=1; done=1 after the 8th grant; inject_cnt=8.
- Sparse and back-pressure: only req 2 valid, InjectSlotAvail toggling 1,0,1,0 -> grants only in slot-available cycles; 2 strobes in 4 cycles; data matches req 2 exactly apart from bit255.
- Pointer skip: rr_ptr=1, req_valid=4'b1001 -> grant req 3, then rr_ptr=0 -> next grant req 0.
- Limit and default: start with cfg_total=0 and a continuous request -> exactly 256 strobes, then DONE; requests remain pending with req_ready=0. A second start with cfg_total=3 -> 3 more strobes and inject_cnt=3.
- Reset mid-run: rst asserted in the same cycle as a grant -> no strobe on the next cycle; all outputs return to reset values; FSM=IDLE.
